// File: rtl/tribus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// State encoding is fixed so that waveform decoders stay stable across builds.
package tribus_pkg;

    localparam int DEF_N          = 4;
    localparam int DEF_MAX_HOLD   = 4;
    localparam int DEF_TURNAROUND = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker, first set req bit above last (mod N).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; evaluates req every cycle, caller decides when to use it.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           any,
    output logic [IDW-1:0] win_idx,
    output logic [N-1:0]   win_onehot
);

    always_comb begin
        logic [IDW-1:0] idx;
        idx        = '0;
        any        = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(last) + i) % N);
            if (!any && req[idx]) begin
                any     = 1'b1;
                win_idx = idx;
            end
        end
        if (any) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Purpose: round-robin owner sequencer driving one-hot bufif1 enables with all-off turnaround gaps.
// Latency: req -> en is 1 cycle; handover gap is exactly TURNAROUND cycles.
// Backpressure: requesters hold req level until granted; owner is preempted after MAX_HOLD if others wait.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter  int N          = DEF_N,
    parameter  int MAX_HOLD   = DEF_MAX_HOLD,
    parameter  int TURNAROUND = DEF_TURNAROUND,
    localparam int IDW        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] owner,
    output logic           bus_busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    state_t         state_q, state_d;
    logic [N-1:0]   en_q, en_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_q, last_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           busy_q;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   pick_onehot;
    logic           do_grant;
    logic           others_wait;

    rr_pick #(.N(N)) u_pick (
        .req        (req),
        .last       (last_q),
        .any        (pick_any),
        .win_idx    (pick_idx),
        .win_onehot (pick_onehot)
    );

    // en_q is one-hot on the owner while in GRANT, so masking with it isolates competitors
    assign others_wait = |(req & ~en_q);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        owner_d  = owner_q;
        last_d   = last_q;
        hold_d   = hold_q;
        tcnt_d   = tcnt_q;
        do_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_grant = pick_any;
            end
            ST_GRANT: begin
                if (!req[owner_q] || (hold_q == HW'(MAX_HOLD) && others_wait)) begin
                    state_d = ST_TURN;
                    en_d    = '0;
                    tcnt_d  = '0;
                    hold_d  = '0;
                end else if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_TURN: begin
                if (tcnt_q == TW'(TURNAROUND - 1)) begin
                    do_grant = pick_any;
                    if (!pick_any) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
        endcase

        if (do_grant) begin
            state_d = ST_GRANT;
            en_d    = pick_onehot;
            owner_d = pick_idx;
            last_d  = pick_idx;
            hold_d  = HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            owner_q <= '0;
            last_q  <= IDW'(N - 1);
            hold_q  <= '0;
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= |en_d;
        end
    end

    assign en       = en_q;
    assign grant    = en_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboarded bench: randomized and directed req against an owner/gap reference model,
// with a bufif1 driver array on one net.
module tb_tribus_arbiter;

    localparam int N          = 4;
    localparam int MAX_HOLD   = 4;
    localparam int TURNAROUND = 1;
    localparam int IDW        = $clog2(N);

    typedef struct {
        logic [N-1:0] en;
        int           own;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   en;
    logic [N-1:0]   grant;
    logic [IDW-1:0] owner;
    logic           bus_busy;

    logic [N-1:0]   drv_dat;
    wire            bus_net;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_last  = N - 1;

    always #5 clk = ~clk;

    tribus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .en       (en),
        .grant    (grant),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign drv_dat[i] = (i % 2 == 1);
        bufif1 u_drv (bus_net, drv_dat[i], en[i]);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: one owner at a time, held count, remaining gap cycles, last winner
    task automatic model_edge(input logic [N-1:0] r, input logic rs);
        exp_t e;
        if (rs) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || (m_held >= MAX_HOLD && (r & ~(N'(1) << m_owner)) != 0)) begin
                m_owner = -1;
                m_gap   = TURNAROUND;
            end else begin
                m_held++;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0 && r != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c = (m_last + k) % N;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner;
                m_held = 1;
            end
        end
        e.en  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.own = m_owner;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        model_edge(r, rs);
    endtask

    task automatic hold(input logic [N-1:0] r, input int cycles);
        for (int c = 0; c < cycles; c++) step(r, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("en", 32'(en), 32'(e.en));
                check("grant", 32'(grant), 32'(e.en));
                check("bus_busy", 32'(bus_busy), 32'(e.en != '0));
                check("onehot", 32'($countones(en) <= 1), 32'd1);
                if (e.own >= 0) begin
                    check("owner", 32'(owner), 32'(e.own));
                    check("net", 32'(bus_net), 32'(drv_dat[e.own]));
                end
            end
        end
    end

    initial begin : stim
        logic [N-1:0] cur;
        step('0, 1'b1);
        step('0, 1'b1);
        hold(4'b0000, 5);
        hold(4'b0001, 3);
        hold(4'b0000, 4);
        hold(4'b1111, 25);
        hold(4'b0000, 3);
        hold(4'b0010, 10);
        hold(4'b0000, 3);
        hold(4'b0100, 6);
        hold(4'b1001, 6);
        hold(4'b0000, 3);
        hold(4'b0100, 3);
        step(4'b0100, 1'b1);
        hold(4'b1111, 12);
        cur = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) cur = N'($urandom);
            step(cur, $urandom_range(99) == 0);
        end
        hold(4'b0000, 3);
        for (int t = 0; t < 10 && sb_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
